rename_stage: RTL
=================

Name: rename_stage

Overview:
- Register-rename stage sitting between decode and dispatch, and directly upstream of the physical-register free list.
- Translates architectural rs1/rs2/rd into physical tags using a 32-entry map table.
- Pops one new physical register per destination-writing instruction from the free list.
- Holds one branch checkpoint of the map table for mispredict recovery, paired with the free list's single snapshot.

Parameters:
- ARCH_REGS, 32, architectural register count (x0..x31).
- PREG_W, 7, physical tag width (128 physical registers).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_rs1  in  5  source 1 architectural index.
- in_rs2  in  5  source 2 architectural index.
- in_rd  in  5  destination architectural index.
- in_has_rd  in  1  instruction writes rd.
- in_is_branch  in  1  instruction needs a checkpoint.
- fl_pd_new  in  PREG_W  head of free list.
- fl_empty  in  1  free list empty.
- fl_read_en  out  1  pop free list this cycle.
- out_valid  out  1  renamed instruction valid.
- out_ready  in  1  dispatch accepts.
- out_ps1  out  PREG_W  physical source 1.
- out_ps2  out  PREG_W  physical source 2.
- out_pd_new  out  PREG_W  new destination tag.
- out_pd_old  out  PREG_W  previous mapping of rd (freed at commit).
- out_alloc  out  1  pd_new/pd_old meaningful.
- ckpt_take  out  1  one-cycle pulse: free list must snapshot now.
- br_resolve  in  1  oldest branch resolved correct.
- mispredict  in  1  oldest branch mispredicted; recover.

Behaviour:
- Reset:
  - map[i] = i for i in 0..31, so p0..p31 back x0..x31 (free list starts at p32).
  - Checkpoint copy = identity; ckpt_valid = 0; out_valid = 0; ckpt_take = 0; all out_* data = 0.
  - Reset mid-operation discards any held instruction and the checkpoint.
- need_alloc = in_has_rd && (in_rd != 0). x0 is never renamed: rd = 0 gives out_alloc = 0 and out_pd_new/out_pd_old = 0.
- Stall when any of the following holds; then in_ready = 0:
  - out_valid && !out_ready;
  - need_alloc && fl_empty;
  - in_is_branch && ckpt_valid (only one branch in flight);
  - mispredict.
- fire = in_valid && in_ready.
- fl_read_en = fire && need_alloc. Combinational, same cycle; fl_pd_new is consumed that cycle.
- On fire (registered, latency 1 cycle):
  - out_ps1 = map[rs1], out_ps2 = map[rs2], read before this instruction's update, so rs == rd gets the old tag.
  - out_pd_old = map[rd]; out_pd_new = fl_pd_new; out_alloc = need_alloc.
  - map[rd] <= fl_pd_new.
- Output register:
  - Holds its contents while out_valid && !out_ready.
  - out_valid clears when out_ready && !fire.
  - Back-to-back fire every cycle when out_ready = 1.
- Branch fire:
  - Checkpoint <= map table including this instruction's own rd update (jal/jalr); ckpt_valid <= 1.
  - ckpt_take pulses in the following cycle, after the free-list r_ptr has advanced, so both snapshots are consistent.
- br_resolve: ckpt_valid <= 0. A new branch may fire from the next cycle.
- mispredict (highest priority):
  - If ckpt_valid, map <= checkpoint. If !ckpt_valid, map is unchanged.
  - ckpt_valid <= 0; out_valid <= 0; fl_read_en = 0; ckpt_take suppressed.
- Simultaneous events:
  - mispredict and br_resolve in the same cycle: mispredict wins.
  - mispredict and a pending out_valid && !out_ready: the output is dropped.
- map[0] is never written and always reads 0.
- Tags are plain PREG_W values; no arithmetic wrap in this block.

Test Plan:
- Reset, then rename add x5,x1,x2 with fl_pd_new = 32 -> next cycle ps1 = 1, ps2 = 2, pd_new = 32, pd_old = 5, out_alloc = 1, fl_read_en high 1 cycle.
- Rename x5 twice back-to-back (pd 32, then 33), the second with rs1 = x5 -> second ps1 = 32, pd_old = 32; an add x5,x5,x0 gets ps1 = old tag, not the new one.
- rd = x0 with has_rd = 1 -> fl_read_en = 0, out_alloc = 0, map[0] still 0; fl_empty = 1 with need_alloc -> in_ready = 0 until fl_empty drops.
- out_ready held 0 for 3 cycles with in_valid = 1 -> outputs stable, no pops, no map writes; release -> one instruction per cycle.
- Branch (rd = x1, pd 40), then x3 -> 41, then mispredict -> map[1] = 40, map[3] = 3, out_valid = 0; a second branch while ckpt_valid stalls until br_resolve.
- Branch fire -> ckpt_take exactly 1 cycle later; mispredict and br_resolve asserted together -> restore occurs; reset mid-stall -> out_valid = 0, identity map.

Source files
------------

// File: rtl/rename_stage.sv
// Register-rename stage: maps rs1/rs2/rd to physical tags, pops the free list, holds one branch checkpoint.
// Latency 1 cycle (registered output); in_ready drops when output is held, free list is empty, a second branch arrives, or on mispredict.
module rename_stage #(
    parameter int ARCH_REGS = 32,
    parameter int PREG_W    = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_has_rd,
    input  logic              in_is_branch,
    input  logic [PREG_W-1:0] fl_pd_new,
    input  logic              fl_empty,
    output logic              fl_read_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PREG_W-1:0] out_ps1,
    output logic [PREG_W-1:0] out_ps2,
    output logic [PREG_W-1:0] out_pd_new,
    output logic [PREG_W-1:0] out_pd_old,
    output logic              out_alloc,
    output logic              ckpt_take,
    input  logic              br_resolve,
    input  logic              mispredict
);

    typedef struct packed {
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd_new;
        logic [PREG_W-1:0] pd_old;
        logic              alloc;
    } ren_t;

    logic [PREG_W-1:0] r_map      [ARCH_REGS];
    logic [PREG_W-1:0] r_ckpt     [ARCH_REGS];
    logic [PREG_W-1:0] w_map_next [ARCH_REGS];
    logic              r_ckpt_valid;
    logic              r_out_valid;
    logic              r_ckpt_take;
    ren_t              r_out;
    ren_t              w_ren;
    logic              w_need_alloc;
    logic              w_fire;

    // x0 is never renamed, so map[0] stays 0 forever.
    assign w_need_alloc = in_has_rd && (in_rd != 5'd0);

    assign in_ready = !(r_out_valid && !out_ready)
                   && !(w_need_alloc && fl_empty)
                   && !(in_is_branch && r_ckpt_valid)
                   && !mispredict;

    assign w_fire     = in_valid && in_ready;
    assign fl_read_en = w_fire && w_need_alloc;

    // Sources read the table before this instruction's own rd update.
    always_comb begin
        w_ren        = '0;
        w_ren.ps1    = r_map[in_rs1];
        w_ren.ps2    = r_map[in_rs2];
        w_ren.alloc  = w_need_alloc;
        if (w_need_alloc) begin
            w_ren.pd_new = fl_pd_new;
            w_ren.pd_old = r_map[in_rd];
        end
    end

    always_comb begin
        for (int i = 0; i < ARCH_REGS; i++) begin
            w_map_next[i] = r_map[i];
        end
        if (fl_read_en) begin
            w_map_next[in_rd] = fl_pd_new;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_map[i]  <= PREG_W'(i);
                r_ckpt[i] <= PREG_W'(i);
            end
            r_ckpt_valid <= 1'b0;
            r_out_valid  <= 1'b0;
            r_ckpt_take  <= 1'b0;
            r_out        <= '0;
        end else begin
            // Pulse lands after the free list has popped this branch's own tag.
            r_ckpt_take <= w_fire && in_is_branch;
            if (mispredict) begin
                if (r_ckpt_valid) begin
                    for (int i = 0; i < ARCH_REGS; i++) begin
                        r_map[i] <= r_ckpt[i];
                    end
                end
                r_ckpt_valid <= 1'b0;
                r_out_valid  <= 1'b0;
            end else begin
                for (int i = 0; i < ARCH_REGS; i++) begin
                    r_map[i] <= w_map_next[i];
                end
                if (w_fire && in_is_branch) begin
                    for (int i = 0; i < ARCH_REGS; i++) begin
                        r_ckpt[i] <= w_map_next[i];
                    end
                    r_ckpt_valid <= 1'b1;
                end else if (br_resolve) begin
                    r_ckpt_valid <= 1'b0;
                end
                if (w_fire) begin
                    r_out_valid <= 1'b1;
                    r_out       <= w_ren;
                end else if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_ps1    = r_out.ps1;
    assign out_ps2    = r_out.ps2;
    assign out_pd_new = r_out.pd_new;
    assign out_pd_old = r_out.pd_old;
    assign out_alloc  = r_out.alloc;
    assign ckpt_take  = r_ckpt_take && !mispredict;

endmodule
